// File: rtl/struct_fifo.sv
// Synchronous FIFO of {a_flag, a_vector} entries with occupancy and flagged-entry counters.
// Output fields are read from registered storage, so there is no same-cycle input-to-output path.
module struct_fifo #(
    parameter  int VEC_W = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a_flag,
    input  logic [VEC_W-1:0] in_a_vector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a_flag,
    output logic [VEC_W-1:0] out_a_vector,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    flag_count
);
    localparam int AW = $clog2(DEPTH);

    logic [VEC_W:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   flag_count_q, flag_count_d;
    logic            push, pop;
    logic [VEC_W:0]  head;

    assign in_ready     = (count_q != CW'(DEPTH));
    assign out_valid    = (count_q != '0);
    assign push         = in_valid & in_ready & ~flush;
    assign pop          = out_valid & out_ready & ~flush;
    assign head         = mem_q[rd_ptr_q];
    assign out_a_flag   = out_valid & head[VEC_W];
    assign out_a_vector = out_valid ? head[VEC_W-1:0] : '0;
    assign count        = count_q;
    assign flag_count   = flag_count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        flag_count_d = flag_count_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            flag_count_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Both terms apply together when a push and a pop coincide.
            flag_count_d = flag_count_q + CW'(push & in_a_flag) - CW'(pop & head[VEC_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flag_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flag_count_q <= flag_count_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a_flag, in_a_vector};
    end

endmodule

// File: tb/tb_struct_fifo.sv
// Bench for struct_fifo: reference queue updated per clock, monitor on the falling edge.
module tb_struct_fifo;
    localparam int VEC_W = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_a_flag;
    logic [VEC_W-1:0] in_a_vector;
    logic             out_valid;
    logic             out_ready;
    logic             out_a_flag;
    logic [VEC_W-1:0] out_a_vector;
    logic [CW-1:0]    count;
    logic [CW-1:0]    flag_count;

    int errors = 0;
    int checks = 0;
    int pops_seen = 0;

    logic [VEC_W:0] sb_q[$];

    struct_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a_flag    (in_a_flag),
        .in_a_vector  (in_a_vector),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a_flag   (out_a_flag),
        .out_a_vector (out_a_vector),
        .count        (count),
        .flag_count   (flag_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int model_flags();
        int n = 0;
        foreach (sb_q[i]) n += int'(sb_q[i][VEC_W]);
        return n;
    endfunction

    // Reference behaviour: a plain queue, capacity DEPTH, flush empties it.
    always @(posedge clk) begin
        if (rst_n) begin
            bit do_push, do_pop;
            do_push = in_valid && (sb_q.size() != DEPTH) && !flush;
            do_pop  = out_ready && (sb_q.size() != 0) && !flush;
            if (flush) sb_q.delete();
            else begin
                if (do_pop) begin
                    void'(sb_q.pop_front());
                    pops_seen++;
                end
                if (do_push) sb_q.push_back({in_a_flag, in_a_vector});
            end
        end
    end

    always @(negedge rst_n) sb_q.delete();

    // Monitor: compare everything the DUT presents against the reference queue.
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(sb_q.size()));
        chk("flag_count", 64'(flag_count), 64'(model_flags()));
        chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
        if (sb_q.size() != 0) begin
            chk("head_flag", 64'(out_a_flag), 64'(sb_q[0][VEC_W]));
            chk("head_vector", 64'(out_a_vector), 64'(sb_q[0][VEC_W-1:0]));
        end else begin
            chk("idle_flag", 64'(out_a_flag), 64'd0);
            chk("idle_vector", 64'(out_a_vector), 64'd0);
        end
    end

    task automatic step(input logic v, input logic f, input logic [VEC_W-1:0] vec,
                        input logic ordy, input logic fl);
        in_valid    = v;
        in_a_flag   = f;
        in_a_vector = vec;
        out_ready   = ordy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a_flag = 1'b0;
        in_a_vector = '0; out_ready = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single push into empty FIFO is visible one cycle later.
        step(1, 1, 32'hDEADBEEF, 0, 0);
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_vector", 64'(out_a_vector), 64'hDEADBEEF);
        chk("first_count", 64'(count), 64'd1);
        chk("first_flag_count", 64'(flag_count), 64'd1);

        step(1, 0, 32'h1111_0001, 0, 0);
        step(1, 1, 32'h2222_0002, 0, 0);
        step(1, 0, 32'h3333_0003, 0, 0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1, 1, 32'h4444_0004, 1, 0);
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_head", 64'(out_a_vector), 64'h1111_0001);

        // Drain to [D], add flag-0 entry, then push flag=1 while popping the flag-0 head.
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(1, 0, 32'h5555_0005, 0, 0);
        chk("pre_swap_count", 64'(count), 64'd2);
        chk("pre_swap_flags", 64'(flag_count), 64'd0);
        step(1, 1, 32'h6666_0006, 1, 0);
        chk("swap_count", 64'(count), 64'd2);
        chk("swap_flags", 64'(flag_count), 64'd1);

        step(1, 1, 32'h7777_0007, 0, 0);
        chk("pre_flush_count", 64'(count), 64'd3);
        step(1, 1, 32'h8888_0008, 0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_flags", 64'(flag_count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_vector", 64'(out_a_vector), 64'd0);

        // Random traffic with pointer wrap; the monitor checks order and content.
        pops_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        chk("random_pops_ge_10", 64'(pops_seen >= 10), 64'd1);

        // Asynchronous reset between edges with two entries stored.
        step(0, 0, '0, 0, 1);
        step(1, 1, 32'hAAAA_0001, 0, 0);
        step(1, 0, 32'hAAAA_0002, 0, 0);
        chk("pre_reset_count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_flags", 64'(flag_count), 64'd0);
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_flag", 64'(out_a_flag), 64'd0);
        chk("async_vector", 64'(out_a_vector), 64'd0);
        #2 rst_n = 1'b1;
        step(1, 0, 32'hC0FFEE00, 0, 0);
        chk("post_reset_valid", 64'(out_valid), 64'd1);
        chk("post_reset_vector", 64'(out_a_vector), 64'hC0FFEE00);
        chk("post_reset_count", 64'(count), 64'd1);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/struct_fifo.md
STRUCT_FIFO -- requirements
Module: struct_fifo

Interface
REQ-001 SHALL have parameter VEC_W, default 32: width of the a_vector payload field.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; legal values are powers of two, minimum 2.
REQ-003 SHALL define CW = $clog2(DEPTH)+1 as the width of the occupancy ports.
REQ-004 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1: synchronous discard of all stored entries.
REQ-007 SHALL have port in_valid  in  1: the producer offers an entry.
REQ-008 SHALL have port in_ready  out  1: the FIFO can accept an entry.
REQ-009 SHALL have port in_a_flag  in  1: flag field of the offered entry.
REQ-010 SHALL have port in_a_vector  in  VEC_W: vector field of the offered entry.
REQ-011 SHALL have port out_valid  out  1: the head entry is presented.
REQ-012 SHALL have port out_ready  in  1: the consumer takes the head entry.
REQ-013 SHALL have port out_a_flag  out  1: flag field of the head entry.
REQ-014 SHALL have port out_a_vector  out  VEC_W: vector field of the head entry.
REQ-015 SHALL have port count  out  CW: number of stored entries.
REQ-016 SHALL have port flag_count  out  CW: number of stored entries whose a_flag is 1.

Function
REQ-017 SHALL treat push as in_valid & in_ready & !flush, and pop as out_valid & out_ready & !flush.
REQ-018 SHALL drive in_ready = (count != DEPTH), independent of out_ready; a full FIFO SHALL NOT accept an entry even when a pop occurs in the same cycle.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL present an entry at the output one cycle after its push into an empty FIFO; there SHALL be no same-cycle combinational path from input to output.
REQ-021 SHALL drive out_a_flag and out_a_vector from the head entry when out_valid=1, and drive both to 0 when out_valid=0.
REQ-022 SHALL preserve strict FIFO order and the bit-exact {a_flag, a_vector} content of every entry.
REQ-023 SHALL advance the write and read pointers modulo DEPTH on push and pop respectively.
REQ-024 SHALL update count by +1 on push only, by -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-025 SHALL update flag_count by +in_a_flag on push and by -out_a_flag on pop, both applied in the same cycle when push and pop coincide.
REQ-026 SHALL, when flush=1, set pointers, count and flag_count to 0 at the next edge, with flush taking priority over push and pop in that cycle.
REQ-027 SHALL never overflow or underflow count or flag_count; flag_count SHALL always be <= count.
REQ-028 SHALL leave storage contents unreset; only pointers and counters carry reset values.

Reset
REQ-029 SHALL, while rst_n=0, force immediately and asynchronously: pointers=0, count=0, flag_count=0, out_valid=0, in_ready=1, out_a_flag=0, out_a_vector=0.
REQ-030 SHALL, on rst_n assertion mid-operation, discard all stored entries and accept none in that cycle.
REQ-031 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Verification
REQ-032 Bench SHALL cover: VEC_W=32, DEPTH=4; push {1,0xDEADBEEF} into an empty FIFO -> next cycle out_valid=1, out_a_vector=0xDEADBEEF, count=1, flag_count=1.
REQ-033 Bench SHALL cover: push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th offer plus a pop in the same cycle -> 5th not accepted, count=3.
REQ-034 Bench SHALL cover: at count=2, push flag=1 with a simultaneous pop of a flag=0 head -> count=2, flag_count incremented by 1.
REQ-035 Bench SHALL cover: 10 pushes and pops interleaved at DEPTH=4 (pointer wrap) -> output order and data match a reference queue exactly.
REQ-036 Bench SHALL cover: flush=1 at count=3 while in_valid=1 -> next cycle count=0, flag_count=0, out_valid=0, out_a_vector=0.
REQ-037 Bench SHALL cover: rst_n=0 between clock edges at count=2 -> outputs reach reset values without a clk edge; after release, the first push appears after one cycle.
